// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight, IDLE/ISSUE/WAIT/RESP sequencing onto a 1-cycle-latency memory port.
// Define MISALIGNED_SPLIT_EN to split misaligned half/word accesses into byte accesses; otherwise they fault.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        split_q, split_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        illegal, misal, fault, split, last_byte;
  logic [31:0] shifted;

  assign illegal = req_write ? (req_funct3[2] || req_funct3 == 3'b011)
                             : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
  assign misal   = (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) ||
                   (req_funct3[1:0] == 2'b01 && req_addr[0]);
`ifdef MISALIGNED_SPLIT_EN
  assign fault = illegal;
  assign split = misal && !illegal;
`else
  assign fault = illegal || misal;
  assign split = 1'b0;
`endif

  // Split loads shift each byte in from the top; a word ends fully assembled, a half ends in [31:16].
  assign shifted   = {mem_read_data[7:0], rdata_q[31:8]};
  assign last_byte = (cnt_q == (funct3_q[1] ? 2'd3 : 2'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b010;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      split_q  <= split_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    split_d    = split_q;
    cnt_d      = cnt_q;
    mem_write  = 1'b0;
    mem_funct3 = 3'b010;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = fault;
          split_d  = split;
          cnt_d    = 2'd0;
          state_d  = fault ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_write  = write_q;
        mem_funct3 = split_q ? (write_q ? 3'b000 : 3'b100) : funct3_q;
        if (!write_q) begin
          state_d = WAIT;
        end else if (split_q && !last_byte) begin
          addr_d  = addr_q + 32'd1;
          wdata_d = {8'h0, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (!split_q) begin
          rdata_d = mem_read_data;
          state_d = RESP;
        end else if (!last_byte) begin
          rdata_d = shifted;
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q + 2'd1;
          state_d = ISSUE;
        end else begin
          if (funct3_q[1])
            rdata_d = shifted;
          else
            rdata_d = {{16{shifted[31] & ~funct3_q[2]}}, shifted[31:16]};
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready         = (state_q == IDLE);
  assign rsp_valid         = (state_q == RESP);
  assign rsp_rdata         = rdata_q;
  assign rsp_error         = err_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_write_data    = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 8kB byte memory model, scoreboard of expected responses and latencies.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_error, mem_write;
  logic [31:0] rsp_rdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data = 32'h0;

  int total = 0, passed = 0;

  typedef struct { logic [31:0] rd; logic err; int lat; int nwr; } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:8191];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [12:0] i;
    i = a[12:0];
    return mem[i];
  endfunction

  // Memory returns loads already extended per funct3.
  function automatic logic [31:0] mrd(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = mb(a); b1 = mb(a + 32'd1); b2 = mb(a + 32'd2); b3 = mb(a + 32'd3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic wb(input logic [31:0] a, input logic [7:0] d);
    logic [12:0] i;
    i = a[12:0];
    mem[i] = d;
  endtask

  task automatic setw(input logic [31:0] a, input logic [31:0] d);
    wb(a, d[7:0]); wb(a + 32'd1, d[15:8]); wb(a + 32'd2, d[23:16]); wb(a + 32'd3, d[31:24]);
  endtask

  always @(posedge clk) begin
    mem_read_data <= mrd(mem_read_address, mem_funct3);
    if (mem_write) begin
      wb(mem_write_address, mem_write_data[7:0]);
      if (mem_funct3[1:0] != 2'b00) wb(mem_write_address + 32'd1, mem_write_data[15:8]);
      if (mem_funct3[1:0] == 2'b10) begin
        wb(mem_write_address + 32'd2, mem_write_data[23:16]);
        wb(mem_write_address + 32'd3, mem_write_data[31:24]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic xact(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                      input int elat, input int enwr);
    exp_t e;
    int lat, nwr;
    logic got;
    sb.push_back('{erd, eerr, elat, enwr});
    @(negedge clk);
    chk({tag, " ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nwr = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
      else if (mem_write) nwr++;
    end
    e = sb.pop_front();
    chk({tag, " rsp"}, {31'h0, got}, 32'd1);
    if (got) begin
      chk({tag, " lat"}, lat, e.lat);
      chk({tag, " rdata"}, rsp_rdata, e.rd);
      chk({tag, " err"}, {31'h0, rsp_error}, {31'h0, e.err});
      chk({tag, " nwr"}, nwr, e.nwr);
      @(negedge clk);
      chk({tag, " pulse"}, {31'h0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
    chk({tag, " rsp_error"}, {31'h0, rsp_error}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " mem_write"}, {31'h0, mem_write}, 32'd0);
    chk({tag, " mem_funct3"}, {29'h0, mem_funct3}, 32'd2);
    chk({tag, " waddr"}, mem_write_address, 32'd0);
    chk({tag, " raddr"}, mem_read_address, 32'd0);
    chk({tag, " wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    #2 chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // store then load back
    xact("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    xact("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

    // byte/half loads with sign/zero extension
    setw(32'h200, 32'h80FF7F01);
    xact("lb201", 1'b0, 3'b000, 32'h201, 32'h0, 32'h0000007F, 1'b0, 3, 0);
    xact("lbu203", 1'b0, 3'b100, 32'h203, 32'h0, 32'h00000080, 1'b0, 3, 0);
    xact("lh202", 1'b0, 3'b001, 32'h202, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);

    // illegal funct3
    xact("ld011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("st100", 1'b1, 3'b100, 32'h40, 32'h12345678, 32'h0, 1'b1, 1, 0);
    xact("st011", 1'b1, 3'b011, 32'h40, 32'h12345678, 32'h0, 1'b1, 1, 0);
    xact("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 3, 0);

    // misaligned accesses
    setw(32'h100, 32'h44332211);
    setw(32'h104, 32'h88776655);
    wb(32'h108, 8'hC3);
    wb(32'h1FFF, 8'hAB);
    wb(32'h0, 8'h01); wb(32'h1, 8'h02); wb(32'h2, 8'h03);
    xact("lbFFFF", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFAB, 1'b0, 3, 0);
`ifdef MISALIGNED_SPLIT_EN
    xact("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h66554433, 1'b0, 9, 0);
    xact("lh107", 1'b0, 3'b001, 32'h107, 32'h0, 32'hFFFFC388, 1'b0, 5, 0);
    xact("lhu107", 1'b0, 3'b101, 32'h107, 32'h0, 32'h0000C388, 1'b0, 5, 0);
    xact("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h030201AB, 1'b0, 9, 0);
    xact("sh301", 1'b1, 3'b001, 32'h301, 32'h0000BEEF, 32'h0, 1'b0, 3, 2);
    xact("lw300", 1'b0, 3'b010, 32'h300, 32'h0, 32'h00BEEF00, 1'b0, 3, 0);

    // reset during the second byte of a split store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h101; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("split2 mem_write", {31'h0, mem_write}, 32'd1);
    chk("split2 addr", mem_write_address, 32'h102);
    rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst no rsp", {31'h0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst b101", {24'h0, mb(32'h101)}, 32'hDD);
    chk("rst b102", {24'h0, mb(32'h102)}, 32'h33);
    chk("rst b103", {24'h0, mb(32'h103)}, 32'h44);
    chk("rst b104", {24'h0, mb(32'h104)}, 32'h55);
`else
    xact("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lh107", 1'b0, 3'b001, 32'h107, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lhu107", 1'b0, 3'b101, 32'h107, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("sh301", 1'b1, 3'b001, 32'h301, 32'h0000BEEF, 32'h0, 1'b1, 1, 0);
    xact("lw300", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 3, 0);
    xact("sw101", 1'b1, 3'b010, 32'h101, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0);
    chk("sw101 b101", {24'h0, mb(32'h101)}, 32'h22);
    chk("sw101 b102", {24'h0, mb(32'h102)}, 32'h33);

    // reset pulse while a load is waiting on memory
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst no rsp", {31'h0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
`endif

    // first request after reset release is accepted immediately
    xact("postrst lw200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h80FF7F01, 1'b0, 3, 0);
    chk("sb empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
